// File: rtl/digit_scanner_if.sv
// Digit scanner bus: BCD digit load strobe in, raster timing and digit-cell lookup out.
interface digit_scanner_if;
  logic [15:0] digits_in;
  logic        digits_valid;
  logic [9:0]  sx;
  logic [9:0]  sy;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [9:0]  sx_offset;
  logic [9:0]  sy_offset;
  logic [3:0]  number;
  logic        slot_active;
  logic        frame_start;

  modport master (
    output digits_in, digits_valid,
    input  sx, sy, hsync, vsync, de, sx_offset, sy_offset, number, slot_active, frame_start
  );

  modport slave (
    input  digits_in, digits_valid,
    output sx, sy, hsync, vsync, de, sx_offset, sy_offset, number, slot_active, frame_start
  );
endinterface

// File: rtl/digit_scanner.sv
// Raster scanner that maps each pixel onto one of four BCD digit cells.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (slot 3 always shown).
module digit_scanner #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CELL_X0    = 100,
  parameter int CELL_PITCH = 120,
  parameter int CELL_W     = 81,
  parameter int CELL_Y0    = 170,
  parameter int CELL_H     = 141
) (
  input  logic        clk,
  input  logic        rst_n,
  digit_scanner_if.slave bus
);
  localparam int NUM_SLOTS = 4;
  localparam int DIG_W     = 4;
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] YL     = 10'(CELL_Y0);
  localparam logic [9:0] YH     = 10'(CELL_Y0 + CELL_H - 1);

  logic [1:0]  div;
  logic        tick, wrap;
  logic [9:0]  sx, sy, nx, ny;
  logic [15:0] shadow, active, active_nxt;

  logic [NUM_SLOTS-1:0]            hit, blank;
  logic [NUM_SLOTS-1:0][9:0]       x_off;
  logic [NUM_SLOTS-1:0][DIG_W-1:0] dig;
  logic                            hit_any;
  logic [9:0]                      xo_sel, yo_sel;
  logic [DIG_W-1:0]                num_sel;

  logic             hsync_q, vsync_q, de_q, act_q, fs_q;
  logic [9:0]       xo_q, yo_q;
  logic [DIG_W-1:0] num_q;

  assign tick = (div == 2'd3);

  always_comb begin
    nx = (sx == H_LAST) ? '0 : sx + 10'd1;
    ny = sy;
    if (sx == H_LAST) ny = (sy == V_LAST) ? '0 : sy + 10'd1;
  end

  // A load strobe landing on the wrap tick goes straight to the active digits.
  assign wrap       = tick && (nx == '0) && (ny == '0);
  assign active_nxt = wrap ? (bus.digits_valid ? bus.digits_in : shadow) : active;

  // Everything below looks at the next pixel so registered outputs line up with sx/sy.
  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    localparam logic [9:0] XL = 10'(CELL_X0 + k*CELL_PITCH);
    localparam logic [9:0] XH = 10'(CELL_X0 + k*CELL_PITCH + CELL_W - 1);
    assign hit[k]   = (nx >= XL) && (nx <= XH) && (ny >= YL) && (ny <= YH);
    assign x_off[k] = nx - XL;
    assign dig[k]   = active_nxt[(NUM_SLOTS-1-k)*DIG_W +: DIG_W];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int k = 0; k < NUM_SLOTS-1; k++) begin
      lead     = lead && (dig[k] == '0);
      blank[k] = lead;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    hit_any = 1'b0;
    xo_sel  = '0;
    yo_sel  = '0;
    num_sel = '1;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (hit[k]) begin
        hit_any = 1'b1;
        xo_sel  = x_off[k];
        yo_sel  = ny - YL;
        num_sel = blank[k] ? '1 : dig[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div     <= '0;
      sx      <= '0;
      sy      <= '0;
      shadow  <= '0;
      active  <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      xo_q    <= '0;
      yo_q    <= '0;
      num_q   <= '1;
      act_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      div  <= div + 2'd1;
      fs_q <= wrap;
      if (bus.digits_valid) shadow <= bus.digits_in;
      if (tick) begin
        sx      <= nx;
        sy      <= ny;
        active  <= active_nxt;
        hsync_q <= !((nx >= HS_ON) && (nx <= HS_OFF));
        vsync_q <= !((ny >= VS_ON) && (ny <= VS_OFF));
        de_q    <= (nx < H_ACT) && (ny < V_ACT);
        xo_q    <= xo_sel;
        yo_q    <= yo_sel;
        num_q   <= num_sel;
        act_q   <= hit_any;
      end
    end
  end

  assign bus.sx          = sx;
  assign bus.sy          = sy;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.sx_offset   = xo_q;
  assign bus.sy_offset   = yo_q;
  assign bus.number      = num_q;
  assign bus.slot_active = act_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_digit_scanner.sv
// Bench: a scaled-down scanner for frame-level behaviour plus a full-size one for line timing.
module tb_digit_scanner;
  typedef struct packed {
    logic [9:0] sx, sy;
    logic       hs, vs, de;
    logic [9:0] xo, yo;
    logic [3:0] num;
    logic       act, fs;
  } obs_t;

  typedef struct packed {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, x0, p, cw, y0, ch;
  } geom_t;

  typedef struct {
    logic [15:0] dig;
    int          x, y;
    logic        act;
    logic [9:0]  xo, yo;
    logic [3:0]  num, num_lzb;
  } vec_t;

  localparam geom_t GS = '{ha:32, hfp:2, hsw:4, hbp:2, va:24, vfp:2, vsw:2, vbp:2,
                           x0:2, p:8, cw:6, y0:8, ch:10};
  localparam geom_t GF = '{ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33,
                           x0:100, p:120, cw:81, y0:170, ch:141};
  localparam int S_HT   = 40;
  localparam int S_VT   = 30;
  localparam int FR_CLK = S_HT * S_VT * 4;
  localparam int NV     = 20;
  localparam obs_t RST_OBS = '{sx:10'd0, sy:10'd0, hs:1'b1, vs:1'b1, de:1'b0,
                               xo:10'd0, yo:10'd0, num:4'hf, act:1'b0, fs:1'b0};
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  digit_scanner_if sbus();
  digit_scanner_if fbus();

  digit_scanner #(
    .H_ACTIVE(GS.ha), .H_FP(GS.hfp), .H_SYNC(GS.hsw), .H_BP(GS.hbp),
    .V_ACTIVE(GS.va), .V_FP(GS.vfp), .V_SYNC(GS.vsw), .V_BP(GS.vbp),
    .CELL_X0(GS.x0), .CELL_PITCH(GS.p), .CELL_W(GS.cw), .CELL_Y0(GS.y0), .CELL_H(GS.ch)
  ) u_small (.clk(clk), .rst_n(rst_n), .bus(sbus));

  digit_scanner u_full (.clk(clk), .rst_n(rst_n), .bus(fbus));

  obs_t s_obs, f_obs;
  assign s_obs = {sbus.sx, sbus.sy, sbus.hsync, sbus.vsync, sbus.de, sbus.sx_offset,
                  sbus.sy_offset, sbus.number, sbus.slot_active, sbus.frame_start};
  assign f_obs = {fbus.sx, fbus.sy, fbus.hsync, fbus.vsync, fbus.de, fbus.sx_offset,
                  fbus.sy_offset, fbus.number, fbus.slot_active, fbus.frame_start};

  int errors = 0;
  int checks = 0;
  int n = 0;
  logic [15:0] shadow_m = '0;
  logic [15:0] active_m = '0;
  bit mon_en = 1'b0;
  bit full_done = 1'b0;
  vec_t tbl[NV];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Expected outputs derived from elapsed clocks since reset release.
  function automatic obs_t model(input geom_t g, input int nclk, input logic [15:0] d);
    obs_t o;
    int t, x, y, ht, vt, k, r;
    bit lead;
    o = RST_OBS;
    if (nclk < 4) return o;
    ht = g.ha + g.hfp + g.hsw + g.hbp;
    vt = g.va + g.vfp + g.vsw + g.vbp;
    t  = nclk / 4;
    x  = t % ht;
    y  = (t / ht) % vt;
    o.sx = 10'(x);
    o.sy = 10'(y);
    o.hs = !(x >= g.ha + g.hfp && x < g.ha + g.hfp + g.hsw);
    o.vs = !(y >= g.va + g.vfp && y < g.va + g.vfp + g.vsw);
    o.de = (x < g.ha) && (y < g.va);
    o.fs = (nclk % 4 == 0) && (t % (ht * vt) == 0);
    if (x >= g.x0 && y >= g.y0 && y < g.y0 + g.ch) begin
      k = (x - g.x0) / g.p;
      r = (x - g.x0) % g.p;
      if (k < 4 && r < g.cw) begin
        o.act = 1'b1;
        o.xo  = 10'(r);
        o.yo  = 10'(y - g.y0);
        o.num = d[15-4*k -: 4];
        if (LZB && k < 3) begin
          lead = 1'b1;
          for (int j = 0; j <= k; j++) if (d[15-4*j -: 4] != 4'd0) lead = 1'b0;
          if (lead) o.num = 4'hf;
        end
      end
    end
    return o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n        <= 0;
      shadow_m <= '0;
      active_m <= '0;
    end else begin
      n <= n + 1;
      if (sbus.digits_valid) shadow_m <= sbus.digits_in;
      if ((n + 1) % 4 == 0 && ((n + 1) / 4) % (S_HT * S_VT) == 0)
        active_m <= sbus.digits_valid ? sbus.digits_in : shadow_m;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("sb_small", s_obs, model(GS, n, active_m));
      check("sb_full", f_obs, model(GF, n, 16'h0000));
    end
  end

  task automatic wait_xy(input int x, input int y);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * FR_CLK; i++) begin
      @(negedge clk);
      if (sbus.sx == 10'(x) && sbus.sy == 10'(y)) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("reach_%0d_%0d", x, y), ok, 1);
  endtask

  task automatic wait_fs();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * FR_CLK; i++) begin
      @(negedge clk);
      if (sbus.frame_start) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_frame_start", ok, 1);
  endtask

  task automatic pulse(input logic [15:0] d);
    @(negedge clk);
    sbus.digits_in    = d;
    sbus.digits_valid = 1'b1;
    @(negedge clk);
    sbus.digits_valid = 1'b0;
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    for (int j = 0; j < 4; j++)
      d[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return d;
  endfunction

  // One full-size line: hsync must be low for 96 ticks.
  initial begin
    int hs_lo;
    hs_lo = 0;
    wait (mon_en);
    @(posedge rst_n);
    repeat (3200) begin
      @(negedge clk);
      if (!fbus.hsync) hs_lo++;
    end
    check("full_hsync_clks", hs_lo, 96 * 4);
    full_done = 1'b1;
  end

  initial begin
    logic [15:0] shown, pending;
    int c, vs_lo, hs_lo;

    tbl[0]  = '{16'h1234,  2,  8, 1'b1, 10'd0, 10'd0, 4'd1,  4'd1};
    tbl[1]  = '{16'h1234,  7,  8, 1'b1, 10'd5, 10'd0, 4'd1,  4'd1};
    tbl[2]  = '{16'h1234,  8,  8, 1'b0, 10'd0, 10'd0, 4'd15, 4'd15};
    tbl[3]  = '{16'h1234, 12, 11, 1'b1, 10'd2, 10'd3, 4'd2,  4'd2};
    tbl[4]  = '{16'h1234,  1, 17, 1'b0, 10'd0, 10'd0, 4'd15, 4'd15};
    tbl[5]  = '{16'h1234,  2, 17, 1'b1, 10'd0, 10'd9, 4'd1,  4'd1};
    tbl[6]  = '{16'h1234, 31, 17, 1'b1, 10'd5, 10'd9, 4'd4,  4'd4};
    tbl[7]  = '{16'h1234,  2, 18, 1'b0, 10'd0, 10'd0, 4'd15, 4'd15};
    tbl[8]  = '{16'h0040,  2, 10, 1'b1, 10'd0, 10'd2, 4'd0,  4'd15};
    tbl[9]  = '{16'h0040, 10, 10, 1'b1, 10'd0, 10'd2, 4'd0,  4'd15};
    tbl[10] = '{16'h0040, 18, 10, 1'b1, 10'd0, 10'd2, 4'd4,  4'd4};
    tbl[11] = '{16'h0040, 26, 10, 1'b1, 10'd0, 10'd2, 4'd0,  4'd0};
    tbl[12] = '{16'h0000,  3, 12, 1'b1, 10'd1, 10'd4, 4'd0,  4'd15};
    tbl[13] = '{16'h0000, 11, 12, 1'b1, 10'd1, 10'd4, 4'd0,  4'd15};
    tbl[14] = '{16'h0000, 19, 12, 1'b1, 10'd1, 10'd4, 4'd0,  4'd15};
    tbl[15] = '{16'h0000, 27, 12, 1'b1, 10'd1, 10'd4, 4'd0,  4'd0};
    tbl[16] = '{16'h9A0F,  4,  9, 1'b1, 10'd2, 10'd1, 4'd9,  4'd9};
    tbl[17] = '{16'h9A0F, 12,  9, 1'b1, 10'd2, 10'd1, 4'd10, 4'd10};
    tbl[18] = '{16'h9A0F, 20,  9, 1'b1, 10'd2, 10'd1, 4'd0,  4'd0};
    tbl[19] = '{16'h9A0F, 28,  9, 1'b1, 10'd2, 10'd1, 4'd15, 4'd15};

    rst_n = 1'b1;
    sbus.digits_in = '0; sbus.digits_valid = 1'b0;
    fbus.digits_in = '0; fbus.digits_valid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check("rst_small", s_obs, RST_OBS);
    check("rst_full", f_obs, RST_OBS);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_tick_sx", {fbus.sx, sbus.sx}, 20'd0);
    @(negedge clk);
    check("first_tick_sx", {fbus.sx, sbus.sx}, {10'd1, 10'd1});

    // Digits loaded mid-frame must not show until the next frame.
    wait_xy(0, 4);
    pulse(16'h1234);
    wait_xy(12, 11);
    check("midframe_hold", {sbus.slot_active, sbus.number}, {1'b1, LZB ? 4'hf : 4'h0});
    shown   = 16'h0000;
    pending = 16'h1234;

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].dig != shown) begin
        if (tbl[i].dig != pending) begin
          pulse(tbl[i].dig);
          pending = tbl[i].dig;
        end
        wait_fs();
        shown = tbl[i].dig;
      end
      wait_xy(tbl[i].x, tbl[i].y);
      check($sformatf("tbl%0d", i),
            {sbus.slot_active, sbus.sx_offset, sbus.sy_offset, sbus.number},
            {tbl[i].act, tbl[i].xo, tbl[i].yo, LZB ? tbl[i].num_lzb : tbl[i].num});
    end

    // Strobe in the clock whose edge wraps to (0,0): visible in that same frame.
    wait_xy(S_HT - 1, S_VT - 1);
    repeat (3) @(negedge clk);
    sbus.digits_in    = 16'h5678;
    sbus.digits_valid = 1'b1;
    @(negedge clk);
    sbus.digits_valid = 1'b0;
    check("coinc_fs", {sbus.frame_start, sbus.sx, sbus.sy}, {1'b1, 20'd0});
    wait_xy(2, 8);
    check("coinc_num", sbus.number, 4'd5);

    wait_fs();
    c = 0; vs_lo = 0; hs_lo = 0;
    do begin
      @(negedge clk);
      c++;
      if (!sbus.vsync) vs_lo++;
      if (!sbus.hsync) hs_lo++;
    end while (!sbus.frame_start && c < 2 * FR_CLK);
    check("frame_period", c, FR_CLK);
    check("vsync_low_clks", vs_lo, 2 * S_HT * 4);
    check("hsync_low_clks", hs_lo, S_VT * 4 * 4);

    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (sbus.digits_valid) sbus.digits_valid = 1'b0;
      else if ($urandom_range(0, 47) == 0) begin
        sbus.digits_in    = rand_digits();
        sbus.digits_valid = 1'b1;
      end
    end
    @(negedge clk);
    sbus.digits_valid = 1'b0;

    // Reset mid-frame takes effect before the next clock edge.
    wait_xy(20, 15);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_small", s_obs, RST_OBS);
    check("async_rst_full", f_obs, RST_OBS);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("restart_pre_sx", sbus.sx, 10'd0);
    @(negedge clk);
    check("restart_sx", {sbus.sx, sbus.sy}, {10'd1, 10'd0});
    repeat (200) @(negedge clk);
    check("full_line_done", full_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
